// File: rtl/transpose_unskew.sv
// transpose_unskew: rotates diagonally skewed PE read lanes back into row order and buffers rows in a small FIFO.
// Latency: in_val at t -> out_val at t+READ_LATENCY+1 (t+READ_LATENCY+2 when UNSKEW_ROT_PIPE_EN is defined).
// Backpressure: none upstream; a beat meeting a full FIFO with no same-cycle pop is dropped and sets sticky overflow.

// unskew_fifo: generic circular buffer with occupancy count.
// Latency: a push is visible at o_dat the cycle after the write edge.
// Backpressure: caller must not push when full without a same-cycle pop, nor pop when empty.
module unskew_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_dat,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dat,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  // Storage array; contents are never read while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_dat;
  end

  // Pointers wrap naturally (DEPTH is a power of two); level counts push minus pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_level = r_level;
endmodule

// transpose_unskew top. Optional register stage between rotator and FIFO: macro UNSKEW_ROT_PIPE_EN.
module transpose_unskew #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_PE       = 8,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_val,
  input  logic [NUM_PE*DATA_WIDTH-1:0]     rd_data,
  output logic                             out_val,
  input  logic                             out_ready,
  output logic [NUM_PE*DATA_WIDTH-1:0]     out_data,
  output logic                             out_last,
  output logic [$clog2(NUM_PE)-1:0]        out_row,
  output logic                             overflow,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);
  localparam int RW = $clog2(NUM_PE);
  localparam int PW = NUM_PE * DATA_WIDTH;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic          last;
    logic [RW-1:0] row;
    logic [PW-1:0] data;
  } beat_t;

  logic [READ_LATENCY-1:0] r_val_sr;
  logic                    w_cap_val;
  logic [RW-1:0]           r_row;
  beat_t                   w_rot_beat;
  beat_t                   w_wr_beat;
  logic                    w_wr_vld;
  beat_t                   w_head;
  logic [LW-1:0]           w_level;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;
  logic                    r_overflow;

  // Output lane j takes input lane (j + row) with the natural RW-bit wrap.
  function automatic logic [PW-1:0] unskew(input logic [PW-1:0] d, input logic [RW-1:0] r);
    logic [RW-1:0] k;
    unskew = '0;
    for (int j = 0; j < NUM_PE; j++) begin
      k = RW'(j) + r;
      unskew[j*DATA_WIDTH +: DATA_WIDTH] = d[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endfunction

  // Delay in_val by the bank read latency so it lines up with rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val_sr <= '0;
    end else begin
      r_val_sr[0] <= in_val;
      for (int i = 1; i < READ_LATENCY; i++) r_val_sr[i] <= r_val_sr[i-1];
    end
  end

  assign w_cap_val = r_val_sr[READ_LATENCY-1];

  // Row counter advances on every captured beat, dropped or not, to keep tile alignment.
  always_ff @(posedge clk) begin
    if (rst)            r_row <= '0;
    else if (w_cap_val) r_row <= r_row + 1'b1;
  end

  // Rotate the captured word and tag it with its row position.
  always_comb begin
    w_rot_beat      = '0;
    w_rot_beat.data = unskew(rd_data, r_row);
    w_rot_beat.row  = r_row;
    w_rot_beat.last = (r_row == RW'(NUM_PE - 1));
  end

`ifdef UNSKEW_ROT_PIPE_EN
  logic  r_pipe_vld;
  beat_t r_pipe_beat;

  // Register stage after the rotator; drop decision is taken on its output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld  <= 1'b0;
      r_pipe_beat <= '0;
    end else begin
      r_pipe_vld <= w_cap_val;
      if (w_cap_val) r_pipe_beat <= w_rot_beat;
    end
  end

  assign w_wr_vld  = r_pipe_vld;
  assign w_wr_beat = r_pipe_beat;
`else
  assign w_wr_vld  = w_cap_val;
  assign w_wr_beat = w_rot_beat;
`endif

  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign w_full = (w_level == LW'(FIFO_DEPTH));
  assign w_pop  = out_val && out_ready;
  assign w_push = w_wr_vld && (!w_full || w_pop);
  assign w_drop = w_wr_vld && w_full && !w_pop;

  unskew_fifo #(
    .W     ($bits(beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dat   (w_wr_beat),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_level (w_level)
  );

  // Sticky overflow: set on any dropped beat, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)         r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  // Outputs are forced to zero while empty so stale memory never leaks out.
  assign out_val    = (w_level != '0);
  assign out_data   = out_val ? w_head.data : '0;
  assign out_row    = out_val ? w_head.row  : '0;
  assign out_last   = out_val ? w_head.last : 1'b0;
  assign overflow   = r_overflow;
  assign fifo_level = w_level;
endmodule

// File: tb/tb_transpose_unskew.sv
// Bench for transpose_unskew: NUM_PE=4, DATA_WIDTH=8, READ_LATENCY=1, FIFO_DEPTH=4.
// A small occupancy/row model feeds a scoreboard queue; the FIFO head is compared every valid cycle.
// Directed scenarios add fixed-value checks on latency, rotation, tagging, overflow and reset.
module tb_transpose_unskew;
  localparam int DW = 8;
  localparam int NP = 4;
  localparam int RL = 1;
  localparam int FD = 4;
  localparam int PW = NP * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_val;
  logic [PW-1:0] rd_data;
  logic          out_val;
  logic          out_ready;
  logic [PW-1:0] out_data;
  logic          out_last;
  logic [1:0]    out_row;
  logic          overflow;
  logic [2:0]    fifo_level;

  transpose_unskew #(
    .DATA_WIDTH   (DW),
    .NUM_PE       (NP),
    .READ_LATENCY (RL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_val     (in_val),
    .rd_data    (rd_data),
    .out_val    (out_val),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_row    (out_row),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] d;
    logic [1:0]    row;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;
  int            m_level;
  logic [1:0]    m_row;
  logic          m_ovf;
  logic          pend_vld;
  logic [PW-1:0] pend_dat;
  logic          chk_en;

  logic          lg_val  [512];
  logic [PW-1:0] lg_dat  [512];
  logic [1:0]    lg_row  [512];
  logic          lg_last [512];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference unskew: output lane j is input lane (j + r) mod NP.
  function automatic logic [PW-1:0] ref_rot(input logic [PW-1:0] d, input int r);
    logic [PW-1:0] o;
    o = '0;
    for (int j = 0; j < NP; j++) o[j*DW +: DW] = d[((j + r) % NP)*DW +: DW];
    return o;
  endfunction

  // Row k of a tile: lane i holds base + 0x10*k + i.
  function automatic logic [PW-1:0] mkrow(input int k, input int base);
    logic [PW-1:0] o;
    for (int i = 0; i < NP; i++) o[i*DW +: DW] = 8'(base + 16*k + i);
    return o;
  endfunction

  // One clock cycle: drive inputs, check at negedge, advance the model for the coming edge.
  task automatic tick(input logic r, input logic v, input logic [PW-1:0] d, input logic rdy);
    logic          cap;
    logic [PW-1:0] cdat;
    logic          pop;
    exp_t          e;
    rst       = r;
    in_val    = v;
    out_ready = rdy;
    cap       = pend_vld;
    cdat      = pend_dat;
    rd_data   = cap ? cdat : $urandom;
    @(negedge clk);
    lg_val[cyc]  = out_val;
    lg_dat[cyc]  = out_data;
    lg_row[cyc]  = out_row;
    lg_last[cyc] = out_last;
    if (chk_en) begin
      check("out_val", 64'(out_val), 64'(m_level != 0));
      check("fifo_level", 64'(fifo_level), 64'(m_level));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (out_val && sb.size() != 0) begin
        check("head_data", 64'(out_data), 64'(sb[0].d));
        check("head_row", 64'(out_row), 64'(sb[0].row));
        check("head_last", 64'(out_last), 64'(sb[0].last));
      end
    end
    pop = (m_level != 0) && rdy;
    if (r) begin
      sb.delete();
      m_level  = 0;
      m_row    = '0;
      m_ovf    = 1'b0;
      pend_vld = 1'b0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (cap) begin
        if (m_level < FD || pop) begin
          e.d    = ref_rot(cdat, int'(m_row));
          e.row  = m_row;
          e.last = (m_row == 2'd3);
          sb.push_back(e);
          m_level++;
        end else begin
          m_ovf = 1'b1;
        end
        m_row = m_row + 2'd1;
      end
      if (pop) m_level--;
      pend_vld = v;
      pend_dat = d;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, rdy);
  endtask

  int t0;
  int t1;

  initial begin
    chk_en    = 1'b0;
    pend_vld  = 1'b0;
    pend_dat  = '0;
    m_level   = 0;
    m_row     = '0;
    m_ovf     = 1'b0;
    rst       = 1'b1;
    in_val    = 1'b0;
    out_ready = 1'b0;
    rd_data   = '0;
    @(posedge clk);
    #1;
    tick(1'b1, 1'b0, '0, 1'b0);
    chk_en = 1'b1;
    tick(1'b1, 1'b0, '0, 1'b0);

    // 1. Reset state on the first cycle after rst deasserts.
    tick(1'b0, 1'b0, '0, 1'b1);
    check("rst_out_val", 64'(out_val), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_out_row", 64'(out_row), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));

    // 2. Single tile with out_ready held high.
    t0 = cyc;
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, mkrow(k, 0), 1'b1);
    idle(4, 1'b1);
    check("s2_lat_early", 64'(lg_val[t0+1]), 64'(0));
    for (int k = 0; k < 4; k++) begin
      check("s2_val", 64'(lg_val[t0+2+k]), 64'(1));
      check("s2_row", 64'(lg_row[t0+2+k]), 64'(k));
      check("s2_last", 64'(lg_last[t0+2+k]), 64'(k == 3));
    end
    check("s2_after", 64'(lg_val[t0+6]), 64'(0));
    check("s2_row0", 64'(lg_dat[t0+2]), 64'(32'h03020100));
    check("s2_row1", 64'(lg_dat[t0+3]), 64'(32'h10131211));
    check("s2_row2", 64'(lg_dat[t0+4]), 64'(32'h21202322));
    check("s2_row3", 64'(lg_dat[t0+5]), 64'(32'h32313033));

    // 3. Backpressure: fill to four, hold, then drain in order.
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, $urandom, 1'b0);
    idle(3, 1'b0);
    check("s3_level", 64'(fifo_level), 64'(4));
    check("s3_overflow", 64'(overflow), 64'(0));
    t1 = cyc;
    idle(5, 1'b1);
    check("s3_drained", 64'(fifo_level), 64'(0));
    check("s3_stable", 64'(lg_dat[t1-1]), 64'(lg_dat[t1-2]));

    // 4. Overflow: six beats into a stalled FIFO; beats five and six are dropped.
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b1, mkrow(k % 4, 8'h40), 1'b0);
    idle(2, 1'b0);
    check("s4_overflow", 64'(overflow), 64'(1));
    check("s4_level", 64'(fifo_level), 64'(4));
    idle(6, 1'b1);
    check("s4_sticky", 64'(overflow), 64'(1));
    t1 = cyc;
    tick(1'b0, 1'b1, mkrow(2, 8'h80), 1'b1);
    idle(3, 1'b1);
    check("s4_next_val", 64'(lg_val[t1+2]), 64'(1));
    check("s4_next_row", 64'(lg_row[t1+2]), 64'(2));
    check("s4_next_data", 64'(lg_dat[t1+2]), 64'(32'ha1a0a3a2));

    // 5. Full FIFO with a pop and a push in the same cycle.
    tick(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, $urandom, 1'b0);
    check("s5_full", 64'(fifo_level), 64'(4));
    tick(1'b0, 1'b0, '0, 1'b1);
    check("s5_level_kept", 64'(fifo_level), 64'(4));
    check("s5_no_ovf", 64'(overflow), 64'(0));
    idle(6, 1'b1);
    check("s5_drained", 64'(fifo_level), 64'(0));

    // 6. Reset mid-tile with beats buffered and in flight.
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, $urandom, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b0);
    check("s6_val", 64'(out_val), 64'(0));
    check("s6_level", 64'(fifo_level), 64'(0));
    check("s6_ovf", 64'(overflow), 64'(0));
    idle(2, 1'b1);
    t1 = cyc;
    tick(1'b0, 1'b1, mkrow(3, 0), 1'b1);
    idle(3, 1'b1);
    check("s6_no_stale", 64'(lg_val[t1+1]), 64'(0));
    check("s6_next_val", 64'(lg_val[t1+2]), 64'(1));
    check("s6_next_row", 64'(lg_row[t1+2]), 64'(0));
    check("s6_next_data", 64'(lg_dat[t1+2]), 64'(32'h33323130));

    // Random traffic with random backpressure.
    for (int i = 0; i < 200; i++) tick(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    idle(8, 1'b1);
    check("rand_drained", 64'(fifo_level), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
